bcd_operand_entry: RTL and testbench
====================================

BCD_OPERAND_ENTRY -- requirements
Module: bcd_operand_entry

Interface
REQ-001 Parameters: DROP_OLDEST, default 0, overflow policy for a 5th digit: 0 = ignore the digit, 1 = shift in and discard the most significant digit.
REQ-002 Ports: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 Ports: key_valid  input  1  one-cycle key strobe, sampled on the rising edge of clk.
REQ-005 Ports: key_code  input  4  codes 0-9 = digit, 10 = ENTER, 11 = CLEAR, 12 = BACKSPACE, 13-15 = ignored.
REQ-006 Ports: a0, a1, a2, a3  output  4 each  operand A BCD digits; a0 is least significant.
REQ-007 Ports: b0, b1, b2, b3  output  4 each  operand B BCD digits; b0 is least significant.
REQ-008 Ports: sel_b  output  1  1 while operand B is being edited.
REQ-009 Ports: operands_valid  output  1  1 only in SHOW state; qualifies a*/b* for the downstream BCD adder.
REQ-010 Ports: digit_cnt  output  3  number of digits (0-4) entered into the operand currently being edited.

Function
REQ-011 The FSM SHALL have exactly three states: ENTER_A, ENTER_B and SHOW.
REQ-012 Keys SHALL act only on a rising edge of clk with key_valid=1; outputs update at that edge (1-cycle latency), and no action occurs with key_valid=0.
REQ-013 A digit in ENTER_A/ENTER_B with digit_cnt<4 SHALL shift the active operand up one digit (x3<=x2, x2<=x1, x1<=x0, x0<=key) and increment digit_cnt.
REQ-014 A digit with digit_cnt=4 SHALL be ignored when DROP_OLDEST=0; when DROP_OLDEST=1 it SHALL shift in, discarding x3, with digit_cnt held at 4.
REQ-015 ENTER in ENTER_A SHALL move to ENTER_B with digit_cnt<=0 and B unchanged (B is zero from reset/CLEAR).
REQ-016 ENTER in ENTER_B SHALL move to SHOW and assert operands_valid.
REQ-017 ENTER with digit_cnt=0 SHALL still advance, treating the operand as 0000.
REQ-018 In SHOW, a digit SHALL clear A and B, load the digit into a0, set digit_cnt=1 and go to ENTER_A, all in one edge.
REQ-019 In SHOW, ENTER and BACKSPACE SHALL be ignored.
REQ-020 CLEAR in any state SHALL zero all digits and digit_cnt and go to ENTER_A.
REQ-021 Codes 13-15 SHALL be no-ops in every state.
REQ-022 Digit registers SHALL only ever hold values 0-9.
REQ-023 sel_b SHALL be 1 exactly in ENTER_B; operands_valid SHALL be 1 exactly in SHOW; both are registered outputs.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force all a*/b* digits to 0, digit_cnt=0, sel_b=0, operands_valid=0 and state ENTER_A.
REQ-025 Reset asserted mid-entry SHALL discard the partial operand; after release the first digit is taken as a new entry.
REQ-026 Keys SHALL be ignored on any edge where rst_n=0.

Configuration
REQ-027 BACKSPACE SHALL be controlled by macro BCD_ENTRY_BACKSPACE_EN.
REQ-028 With the macro defined, code 12 in ENTER_A/ENTER_B with digit_cnt>0 SHALL shift the active operand down (x0<=x1, x1<=x2, x2<=x3, x3<=0) and decrement digit_cnt; with digit_cnt=0 it SHALL be a no-op.
REQ-029 Without the macro, code 12 SHALL be a no-op like codes 13-15, and no backspace logic is synthesized.

Verification
REQ-030 Keys 1,2,3,4,ENTER,5,6,7,8,ENTER -> a3..a0=1234, b3..b0=5678, operands_valid=1 on the edge after the 2nd ENTER, sel_b=1 only between the ENTERs.
REQ-031 DROP_OLDEST=0, keys 9,8,7,6,5 -> A=9876, digit_cnt=4; DROP_OLDEST=1, same keys -> A=8765, digit_cnt=4.
REQ-032 In SHOW with A=1234, B=5678, key 3 -> A=0003, B=0000, state ENTER_A, operands_valid=0, digit_cnt=1.
REQ-033 Keys 4,2,ENTER,7 then CLEAR -> all digits 0, sel_b=0, digit_cnt=0; then ENTER,ENTER -> SHOW with A=B=0000.
REQ-034 Keys 1,2 then rst_n pulsed low between clock edges -> outputs zero immediately; then key 5 -> A=0005.
REQ-035 With BCD_ENTRY_BACKSPACE_EN defined, keys 1,2,3,12 -> A=0012, digit_cnt=2; without it, the same keys -> A=0123, digit_cnt=3; key_code 14 -> no change in either build.

Source files
------------

// File: rtl/bcd_operand_entry.sv
// Two-operand BCD keypad entry FSM feeding a downstream BCD adder.
// Optional backspace key support is enabled by defining BCD_ENTRY_BACKSPACE_EN.
module bcd_operand_entry #(
    parameter bit DROP_OLDEST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic [3:0] b0,
    output logic [3:0] b1,
    output logic [3:0] b2,
    output logic [3:0] b3,
    output logic       sel_b,
    output logic       operands_valid,
    output logic [2:0] digit_cnt
);

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        SHOW
    } state_t;

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] cur;
    logic [15:0] shl;
    logic        is_digit;
    logic        is_enter;
    logic        is_clear;

    assign {a3, a2, a1, a0} = a_q;
    assign {b3, b2, b1, b0} = b_q;

    assign is_digit = (key_code <= 4'd9);
    assign is_enter = (key_code == 4'd10);
    assign is_clear = (key_code == 4'd11);

    assign cur = (state == ENTER_B) ? b_q : a_q;
    assign shl = {cur[11:0], key_code};

`ifdef BCD_ENTRY_BACKSPACE_EN
    logic        is_bs;
    logic [15:0] shr;
    assign is_bs = (key_code == 4'd12);
    assign shr   = {4'h0, cur[15:4]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ENTER_A;
            a_q            <= '0;
            b_q            <= '0;
            digit_cnt      <= '0;
            sel_b          <= 1'b0;
            operands_valid <= 1'b0;
        end else if (key_valid) begin
            if (is_clear) begin
                state          <= ENTER_A;
                a_q            <= '0;
                b_q            <= '0;
                digit_cnt      <= '0;
                sel_b          <= 1'b0;
                operands_valid <= 1'b0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (is_digit) begin
                            if (digit_cnt < 3'd4 || DROP_OLDEST) begin
                                if (state == ENTER_B) b_q <= shl;
                                else                  a_q <= shl;
                            end
                            if (digit_cnt < 3'd4)
                                digit_cnt <= digit_cnt + 3'd1;
                        end else if (is_enter) begin
                            digit_cnt <= '0;
                            if (state == ENTER_A) begin
                                state <= ENTER_B;
                                sel_b <= 1'b1;
                            end else begin
                                state          <= SHOW;
                                sel_b          <= 1'b0;
                                operands_valid <= 1'b1;
                            end
`ifdef BCD_ENTRY_BACKSPACE_EN
                        end else if (is_bs && digit_cnt != 3'd0) begin
                            if (state == ENTER_B) b_q <= shr;
                            else                  a_q <= shr;
                            digit_cnt <= digit_cnt - 3'd1;
`endif
                        end
                    end
                    SHOW: begin
                        // A digit here starts a fresh calculation in one edge
                        if (is_digit) begin
                            state          <= ENTER_A;
                            a_q            <= {12'h000, key_code};
                            b_q            <= '0;
                            digit_cnt      <= 3'd1;
                            operands_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state          <= ENTER_A;
                        sel_b          <= 1'b0;
                        operands_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry; a second instance checks DROP_OLDEST=1.
// Backspace expectations follow BCD_ENTRY_BACKSPACE_EN.
module tb_bcd_operand_entry;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;

    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic       sel_b, operands_valid;
    logic [2:0] digit_cnt;

    logic [3:0] d_a0, d_a1, d_a2, d_a3, d_b0, d_b1, d_b2, d_b3;
    logic       d_sel_b, d_operands_valid;
    logic [2:0] d_digit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_operand_entry #(.DROP_OLDEST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .sel_b(sel_b), .operands_valid(operands_valid), .digit_cnt(digit_cnt)
    );

    bcd_operand_entry #(.DROP_OLDEST(1'b1)) dut_drop (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .a0(d_a0), .a1(d_a1), .a2(d_a2), .a3(d_a3),
        .b0(d_b0), .b1(d_b1), .b2(d_b2), .b3(d_b3),
        .sel_b(d_sel_b), .operands_valid(d_operands_valid),
        .digit_cnt(d_digit_cnt)
    );

    // Drive one key strobe around a single rising edge; return at the negedge after it.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0000) begin
            errors++; $display("FAIL reset_a got %h want 0000", {a3, a2, a1, a0});
        end
        checks++;
        if ({b3, b2, b1, b0} !== 16'h0000) begin
            errors++; $display("FAIL reset_b got %h want 0000", {b3, b2, b1, b0});
        end
        checks++;
        if ({sel_b, operands_valid, digit_cnt} !== 5'b00_000) begin
            errors++;
            $display("FAIL reset_ctl got sel_b=%b ov=%b cnt=%0d want 0 0 0",
                     sel_b, operands_valid, digit_cnt);
        end
    endtask

    task automatic test_basic_entry;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h1234 || digit_cnt !== 3'd4 || sel_b !== 1'b0) begin
            errors++;
            $display("FAIL entry_a got A=%h cnt=%0d sel_b=%b want 1234 4 0",
                     {a3, a2, a1, a0}, digit_cnt, sel_b);
        end
        press(4'd10);
        checks++;
        if (sel_b !== 1'b1 || digit_cnt !== 3'd0 || operands_valid !== 1'b0 ||
            {b3, b2, b1, b0} !== 16'h0000) begin
            errors++;
            $display("FAIL enter_a got sel_b=%b cnt=%0d ov=%b B=%h want 1 0 0 0000",
                     sel_b, digit_cnt, operands_valid, {b3, b2, b1, b0});
        end
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        checks++;
        if ({b3, b2, b1, b0} !== 16'h5678 || sel_b !== 1'b1 || operands_valid !== 1'b0) begin
            errors++;
            $display("FAIL entry_b got B=%h sel_b=%b ov=%b want 5678 1 0",
                     {b3, b2, b1, b0}, sel_b, operands_valid);
        end
        press(4'd10);
        checks++;
        if (operands_valid !== 1'b1 || sel_b !== 1'b0 ||
            {a3, a2, a1, a0, b3, b2, b1, b0} !== 32'h1234_5678) begin
            errors++;
            $display("FAIL show got ov=%b sel_b=%b AB=%h want 1 0 12345678",
                     operands_valid, sel_b, {a3, a2, a1, a0, b3, b2, b1, b0});
        end
    endtask

    task automatic test_show_keys;
        press(4'd10); press(4'd12); press(4'd14);
        checks++;
        if (operands_valid !== 1'b1 ||
            {a3, a2, a1, a0, b3, b2, b1, b0} !== 32'h1234_5678) begin
            errors++;
            $display("FAIL show_ignore got ov=%b AB=%h want 1 12345678",
                     operands_valid, {a3, a2, a1, a0, b3, b2, b1, b0});
        end
        press(4'd3);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0003 || {b3, b2, b1, b0} !== 16'h0000 ||
            operands_valid !== 1'b0 || sel_b !== 1'b0 || digit_cnt !== 3'd1) begin
            errors++;
            $display("FAIL show_digit got A=%h B=%h ov=%b sel_b=%b cnt=%0d want 0003 0000 0 0 1",
                     {a3, a2, a1, a0}, {b3, b2, b1, b0}, operands_valid, sel_b, digit_cnt);
        end
    endtask

    task automatic test_overflow;
        press(4'd11);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h9876 || digit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL ovf_ignore got A=%h cnt=%0d want 9876 4",
                     {a3, a2, a1, a0}, digit_cnt);
        end
        checks++;
        if ({d_a3, d_a2, d_a1, d_a0} !== 16'h8765 || d_digit_cnt !== 3'd4) begin
            errors++;
            $display("FAIL ovf_drop got A=%h cnt=%0d want 8765 4",
                     {d_a3, d_a2, d_a1, d_a0}, d_digit_cnt);
        end
    endtask

    task automatic test_clear;
        press(4'd11);
        press(4'd4); press(4'd2); press(4'd10); press(4'd7);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0042 || {b3, b2, b1, b0} !== 16'h0007 || sel_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear got A=%h B=%h sel_b=%b want 0042 0007 1",
                     {a3, a2, a1, a0}, {b3, b2, b1, b0}, sel_b);
        end
        press(4'd11);
        checks++;
        if ({a3, a2, a1, a0, b3, b2, b1, b0} !== 32'h0 || sel_b !== 1'b0 ||
            digit_cnt !== 3'd0 || operands_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear got AB=%h sel_b=%b cnt=%0d ov=%b want 0 0 0 0",
                     {a3, a2, a1, a0, b3, b2, b1, b0}, sel_b, digit_cnt, operands_valid);
        end
        press(4'd10); press(4'd10);
        checks++;
        if (operands_valid !== 1'b1 || {a3, a2, a1, a0, b3, b2, b1, b0} !== 32'h0) begin
            errors++;
            $display("FAIL empty_enter got ov=%b AB=%h want 1 00000000",
                     operands_valid, {a3, a2, a1, a0, b3, b2, b1, b0});
        end
    endtask

    task automatic test_key_valid_low;
        press(4'd11);
        press(4'd6);
        @(negedge clk);
        key_code = 4'd5;
        @(negedge clk);
        key_code = 4'd10;
        @(negedge clk);
        key_code = 4'd0;
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0006 || digit_cnt !== 3'd1 || sel_b !== 1'b0) begin
            errors++;
            $display("FAIL no_strobe got A=%h cnt=%0d sel_b=%b want 0006 1 0",
                     {a3, a2, a1, a0}, digit_cnt, sel_b);
        end
    endtask

    task automatic test_async_reset;
        press(4'd11);
        press(4'd1); press(4'd2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0000 || digit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got A=%h cnt=%0d want 0000 0",
                     {a3, a2, a1, a0}, digit_cnt);
        end
        // A key strobed while reset is held must be dropped
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd9;
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0000 || digit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL key_in_reset got A=%h cnt=%0d want 0000 0",
                     {a3, a2, a1, a0}, digit_cnt);
        end
        press(4'd5);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0005 || digit_cnt !== 3'd1) begin
            errors++;
            $display("FAIL after_reset got A=%h cnt=%0d want 0005 1",
                     {a3, a2, a1, a0}, digit_cnt);
        end
    endtask

    task automatic test_backspace;
        logic [15:0] exp_a;
        logic [2:0]  exp_cnt;
        press(4'd11);
        press(4'd12);
        checks++;
        if ({a3, a2, a1, a0} !== 16'h0000 || digit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL bs_empty got A=%h cnt=%0d want 0000 0",
                     {a3, a2, a1, a0}, digit_cnt);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd12);
`ifdef BCD_ENTRY_BACKSPACE_EN
        exp_a   = 16'h0012;
        exp_cnt = 3'd2;
`else
        exp_a   = 16'h0123;
        exp_cnt = 3'd3;
`endif
        checks++;
        if ({a3, a2, a1, a0} !== exp_a || digit_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL backspace got A=%h cnt=%0d want %h %0d",
                     {a3, a2, a1, a0}, digit_cnt, exp_a, exp_cnt);
        end
        press(4'd14); press(4'd13); press(4'd15);
        checks++;
        if ({a3, a2, a1, a0} !== exp_a || digit_cnt !== exp_cnt || sel_b !== 1'b0) begin
            errors++;
            $display("FAIL noop_codes got A=%h cnt=%0d sel_b=%b want %h %0d 0",
                     {a3, a2, a1, a0}, digit_cnt, sel_b, exp_a, exp_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_basic_entry;
        test_show_keys;
        test_overflow;
        test_clear;
        test_key_valid_low;
        test_async_reset;
        test_backspace;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
